// File: rtl/decoder_pkg.sv
// Shared constants and types for the 3-to-8 registered decoder.
package decoder_pkg;
  localparam int SEL_W = 3;
  localparam int OUT_N = 8;

  typedef logic [SEL_W-1:0] sel_t;
  // Bit i of a onehot_t drives output line y<i>.
  typedef logic [OUT_N-1:0] onehot_t;
endpackage

// File: rtl/decoder_if.sv
// Select/enable bundle plus raw decoded lines shared between the decoder top and its core.
interface decoder_if;
  import decoder_pkg::*;

  logic    a;
  logic    b;
  logic    c;
  logic    en;
  onehot_t y;

  modport master (output a, output b, output c, output en, input y);
  modport slave  (input a, input b, input c, input en, output y);
endinterface

// File: rtl/decoder_core.sv
// Purely combinational select-to-one-hot translation; no gating, polarity or state here.
module decoder_core
  import decoder_pkg::*;
(
  decoder_if.slave bus
);

  sel_t sel_s;

  assign sel_s = {bus.a, bus.b, bus.c};

  // Translate the 3-bit select into its active-high one-hot line.
  always_comb begin
    bus.y = {OUT_N{1'b0}};
    case (sel_s)
      3'd0:    bus.y = 8'b0000_0001;
      3'd1:    bus.y = 8'b0000_0010;
      3'd2:    bus.y = 8'b0000_0100;
      3'd3:    bus.y = 8'b0000_1000;
      3'd4:    bus.y = 8'b0001_0000;
      3'd5:    bus.y = 8'b0010_0000;
      3'd6:    bus.y = 8'b0100_0000;
      3'd7:    bus.y = 8'b1000_0000;
      default: bus.y = {OUT_N{1'b0}};
    endcase
  end

endmodule

// File: rtl/decoder.sv
// Registered 3-to-8 decoder with optional output inversion.
// Defining DECODER_ENABLE_EN adds the en port that gates decoding; otherwise always enabled.
module decoder
  import decoder_pkg::*;
#(
  parameter bit OUT_ACTIVE_LOW = 1'b0
)
(
  input  logic clk,
  input  logic rst,
  input  logic a,
  input  logic b,
  input  logic c,
`ifdef DECODER_ENABLE_EN
  input  logic en,
`endif
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic y4,
  output logic y5,
  output logic y6,
  output logic y7
);

  // Deasserted level of every line, i.e. what reset and disable produce.
  localparam onehot_t IDLE_PATTERN = OUT_ACTIVE_LOW ? {OUT_N{1'b1}} : {OUT_N{1'b0}};

  decoder_if sel_bus ();

  onehot_t gated_s;
  onehot_t next_s;
  onehot_t y_r;

  assign sel_bus.a = a;
  assign sel_bus.b = b;
  assign sel_bus.c = c;
`ifdef DECODER_ENABLE_EN
  assign sel_bus.en = en;
`else
  assign sel_bus.en = 1'b1;
`endif

  decoder_core u_core (
    .bus (sel_bus)
  );

  // Apply enable gating, then the output polarity.
  always_comb begin
    gated_s = {OUT_N{1'b0}};
    next_s  = {OUT_N{1'b0}};
    if (sel_bus.en) begin
      gated_s = sel_bus.y;
    end else begin
      gated_s = {OUT_N{1'b0}};
    end
    if (OUT_ACTIVE_LOW) begin
      next_s = ~gated_s;
    end else begin
      next_s = gated_s;
    end
  end

  // Output register; reset outranks enable and select.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_r <= IDLE_PATTERN;
    end else begin
      y_r <= next_s;
    end
  end

  assign y0 = y_r[0];
  assign y1 = y_r[1];
  assign y2 = y_r[2];
  assign y3 = y_r[3];
  assign y4 = y_r[4];
  assign y5 = y_r[5];
  assign y6 = y_r[6];
  assign y7 = y_r[7];

endmodule

// File: tb/tb_decoder.sv
// Scoreboard bench for decoder: an active-high and an active-low instance share one stimulus stream.
module tb_decoder;
  import decoder_pkg::*;

  typedef struct {
    logic [7:0] pat;
    int         ones;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] y_vec;
  logic [7:0] yn_vec;
  exp_t       exp_q[$];
  logic [7:0] prev_exp = 8'h00;
  bit         have_prev = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  decoder_if bus ();

  always #5 clk = ~clk;

  assign bus.y = y_vec;

  decoder #(.OUT_ACTIVE_LOW(1'b0)) dut (
    .clk (clk), .rst (rst), .a (bus.a), .b (bus.b), .c (bus.c),
`ifdef DECODER_ENABLE_EN
    .en  (bus.en),
`endif
    .y0 (y_vec[0]), .y1 (y_vec[1]), .y2 (y_vec[2]), .y3 (y_vec[3]),
    .y4 (y_vec[4]), .y5 (y_vec[5]), .y6 (y_vec[6]), .y7 (y_vec[7])
  );

  decoder #(.OUT_ACTIVE_LOW(1'b1)) dut_n (
    .clk (clk), .rst (rst), .a (bus.a), .b (bus.b), .c (bus.c),
`ifdef DECODER_ENABLE_EN
    .en  (bus.en),
`endif
    .y0 (yn_vec[0]), .y1 (yn_vec[1]), .y2 (yn_vec[2]), .y3 (yn_vec[3]),
    .y4 (yn_vec[4]), .y5 (yn_vec[5]), .y6 (yn_vec[6]), .y7 (yn_vec[7])
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got y7..y0=%b, expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs; queue what the outputs must show after the next edge.
  task automatic step(input logic r, input logic [2:0] s, input logic e);
    exp_t x;
    rst    = r;
    bus.a  = s[2];
    bus.b  = s[1];
    bus.c  = s[0];
    bus.en = e;
    #1;
    if (have_prev) begin
      check("hold_between_edges", y_vec, prev_exp);
      check("hold_between_edges_low", yn_vec, ~prev_exp);
    end
    if (r) begin
      x.pat  = 8'h00;
      x.ones = 0;
    end else if (!e) begin
      x.pat  = 8'h00;
      x.ones = 0;
    end else begin
      x.pat  = 8'h01 << s;
      x.ones = 1;
    end
    @(posedge clk);
    exp_q.push_back(x);
    prev_exp  = x.pat;
    have_prev = 1'b1;
    @(negedge clk);
  endtask

  // Monitor: every edge presents a new output word; pop and compare.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        check("decode", y_vec, x.pat);
        check("decode_active_low", yn_vec, ~x.pat);
        n_checks++;
        if ($countones(y_vec) != x.ones) begin
          n_fail++;
          $display("FAIL onehot: got %0d lines asserted, expected %0d", $countones(y_vec), x.ones);
        end
      end
    end
  end

  initial begin
    logic       r;
    logic [2:0] s;
    logic       e;

    // Reset with arbitrary select values.
    for (int i = 0; i < 3; i++) step(1'b1, 3'($urandom_range(0, 7)), 1'b1);

    // Sweep every select, holding each for 10 cycles.
    for (int v = 0; v < 8; v++)
      for (int k = 0; k < 10; k++) step(1'b0, 3'(v), 1'b1);

    // Reset while sel=011, then release.
    step(1'b1, 3'd3, 1'b1);
    step(1'b1, 3'd3, 1'b1);
    step(1'b0, 3'd3, 1'b1);
    step(1'b0, 3'd3, 1'b1);

`ifdef DECODER_ENABLE_EN
    // Disable while sel=110, then enable; also reset beats enable.
    step(1'b0, 3'd6, 1'b0);
    step(1'b0, 3'd6, 1'b0);
    step(1'b0, 3'd6, 1'b1);
    step(1'b1, 3'd6, 1'b1);
    step(1'b0, 3'd6, 1'b0);
`endif

    // Active-low instance: reset then sel=010.
    step(1'b1, 3'd2, 1'b1);
    step(1'b0, 3'd2, 1'b1);

    // Select changes every cycle.
    for (int v = 0; v < 8; v++) step(1'b0, 3'(v), 1'b1);
    for (int v = 7; v >= 0; v--) step(1'b0, 3'(v), 1'b1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 200; i++) begin
      r = ($urandom_range(0, 15) == 0);
      s = 3'($urandom_range(0, 7));
      e = 1'b1;
`ifdef DECODER_ENABLE_EN
      e = ($urandom_range(0, 3) != 0);
`endif
      step(r, s, e);
    end

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected words never compared, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
